// File: rtl/tx_fifo.sv
`timescale 1ns/1ps
// tx_fifo: first-word fall-through transmit FIFO between a bus write port
// and the transmit logic.
//
// Ports
//   PCLK       rising-edge clock
//   CLEAR_B    asynchronous active-low reset
//   PSEL       bus select
//   PWRITE     bus write strobe (a select without it is a bus read, ignored)
//   PWDATA     write data from the bus
//   TxRDY      transmit logic takes the head word this cycle
//   TxDATA     head-of-FIFO word (valid while TxVALID)
//   TxVALID    FIFO not empty
//   TxFULL     all DEPTH entries occupied
//   SSPTXINTR  occupancy at or below DEPTH/2
//   COUNT      current occupancy
//   OVRERR     sticky: a write was attempted while full
module tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   PCLK,
  input  logic                   CLEAR_B,
  input  logic                   PSEL,
  input  logic                   PWRITE,
  input  logic [WIDTH-1:0]       PWDATA,
  input  logic                   TxRDY,
  output logic [WIDTH-1:0]       TxDATA,
  output logic                   TxVALID,
  output logic                   TxFULL,
  output logic                   SSPTXINTR,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   OVRERR
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned HALF = DEPTH / 2;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0] HALF_CNT = HALF[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [AW:0]      count_q, count_d;
  logic             ovr_q, ovr_d;
  logic             wre, rde, full, empty;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  always_comb begin
    // A write while full is dropped even if a read frees a slot on the same edge.
    wre     = PSEL && PWRITE && !full;
    rde     = !empty && TxRDY;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovr_d   = ovr_q | (PSEL && PWRITE && full);
    if (wre) wp_d = wp_q + 1'b1;
    if (rde) rp_d = rp_q + 1'b1;
    case ({wre, rde})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovr_q   <= ovr_d;
    end
  end

  // Storage is not reset; occupancy tracking alone defines which cells are live.
  always_ff @(posedge PCLK) begin
    if (CLEAR_B && wre) mem_q[wp_q] <= PWDATA;
  end

  assign TxDATA    = mem_q[rp_q];
  assign TxVALID   = !empty;
  assign TxFULL    = full;
  assign SSPTXINTR = (count_q <= HALF_CNT);
  assign COUNT     = count_q;
  assign OVRERR    = ovr_q;

endmodule

// File: tb/tb_tx_fifo.sv
`timescale 1ns/1ps
module tb_tx_fifo;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  logic             PCLK = 1'b0;
  logic             CLEAR_B = 1'b0;
  logic             PSEL = 1'b0;
  logic             PWRITE = 1'b0;
  logic [WIDTH-1:0] PWDATA = '0;
  logic             TxRDY = 1'b0;
  logic [WIDTH-1:0] TxDATA;
  logic             TxVALID, TxFULL, SSPTXINTR, OVRERR;
  logic [2:0]       COUNT;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: occupancy count, sticky overrun flag, and a queue of
  // accepted words in arrival order (the scoreboard).
  int             m_count = 0;
  bit             m_ovr = 0;
  logic [WIDTH-1:0] exp_q[$];

  tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .PCLK(PCLK), .CLEAR_B(CLEAR_B), .PSEL(PSEL), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .TxRDY(TxRDY), .TxDATA(TxDATA), .TxVALID(TxVALID),
    .TxFULL(TxFULL), .SSPTXINTR(SSPTXINTR), .COUNT(COUNT), .OVRERR(OVRERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each edge: decide acceptance from the model's own occupancy.
  always @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      m_count = 0;
      m_ovr   = 0;
      exp_q.delete();
    end else begin
      bit wr_try, acc, rd;
      wr_try = PSEL && PWRITE;
      rd     = (m_count != 0) && TxRDY;
      acc    = wr_try && (m_count < DEPTH);
      if (wr_try && m_count == DEPTH) m_ovr = 1;
      if (acc) exp_q.push_back(PWDATA);
      m_count = m_count + (acc ? 1 : 0) - (rd ? 1 : 0);
    end
  end

  // Monitor: mid-cycle compare of status against the model, and of the
  // presented head word against the scoreboard (popped when consumed).
  always @(negedge PCLK) begin
    if (!CLEAR_B) begin
      check("rst_valid", TxVALID, 0);
      check("rst_full", TxFULL, 0);
      check("rst_intr", SSPTXINTR, 1);
      check("rst_count", COUNT, 0);
      check("rst_ovr", OVRERR, 0);
    end else begin
      check("count", COUNT, m_count);
      check("valid", TxVALID, m_count != 0);
      check("full", TxFULL, m_count == DEPTH);
      check("intr", SSPTXINTR, m_count <= DEPTH / 2);
      check("ovr", OVRERR, m_ovr);
      if (TxVALID) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL data: got %0h with TxVALID but nothing expected at %0t", TxDATA, $time);
        end else begin
          logic [WIDTH-1:0] e;
          e = TxRDY ? exp_q.pop_front() : exp_q[0];
          check("data", TxDATA, e);
        end
      end
    end
  end

  task automatic step(input bit sel, input bit wr, input logic [WIDTH-1:0] d, input bit rdy);
    PSEL = sel; PWRITE = wr; PWDATA = d; TxRDY = rdy;
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle_drain(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 1);
  endtask

  task automatic reset_pulse();
    #2 CLEAR_B = 1'b0;
    #1;
    check("rp_count", COUNT, 0);
    check("rp_valid", TxVALID, 0);
    check("rp_ovr", OVRERR, 0);
    check("rp_intr", SSPTXINTR, 1);
    #1 CLEAR_B = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] wd [4];
    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44;

    repeat (2) @(posedge PCLK);
    #1;
    check("reset_count", COUNT, 0);
    check("reset_intr", SSPTXINTR, 1);
    CLEAR_B = 1'b1;

    // Fill with TxRDY low.
    for (int i = 0; i < 4; i++) begin
      step(1, 1, wd[i], 0);
      check("fill_count", COUNT, i + 1);
      check("fill_intr", SSPTXINTR, (i + 1) <= 2);
    end
    check("fill_full", TxFULL, 1);
    check("fill_head", TxDATA, 8'h11);

    // Overrun while full, then drain.
    step(1, 1, 8'h55, 0);
    check("ovr_set", OVRERR, 1);
    check("ovr_count", COUNT, 4);
    idle_drain(4);
    check("drain_valid", TxVALID, 0);
    check("ovr_sticky", OVRERR, 1);

    // Write plus read while full: read completes, write dropped.
    for (int i = 0; i < 4; i++) step(1, 1, wd[i], 0);
    step(1, 1, 8'h66, 1);
    check("fullrw_count", COUNT, 3);
    check("fullrw_full", TxFULL, 0);
    check("fullrw_head", TxDATA, 8'h22);
    idle_drain(4);

    // Steady state at COUNT=2 across several pointer wraps.
    step(1, 1, 8'h80, 0);
    step(1, 1, 8'h81, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 8'h82 + i[7:0], 1);
      check("stream_count", COUNT, 2);
    end
    idle_drain(3);

    // Fall-through from empty; a bus read in between does nothing.
    step(1, 0, 8'hEE, 0);
    check("busrd_count", COUNT, 0);
    step(1, 1, 8'hA5, 0);
    check("fwft_valid", TxVALID, 1);
    check("fwft_data", TxDATA, 8'hA5);
    step(0, 0, '0, 1);
    check("fwft_empty", TxVALID, 0);

    // Mid-cycle reset with three queued words.
    step(1, 1, 8'h01, 0);
    step(1, 1, 8'h02, 0);
    step(1, 1, 8'h03, 0);
    step(1, 1, 8'h04, 0);
    step(1, 1, 8'h05, 0);  // overrun so the reset visibly clears OVRERR
    step(0, 0, '0, 1);
    check("pre_rst_count", COUNT, 3);
    reset_pulse();
    step(1, 1, 8'h77, 0);
    check("post_rst_data", TxDATA, 8'h77);
    check("post_rst_count", COUNT, 1);

    // Randomized traffic with varying read pressure and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      int unsigned bias;
      bias = (i / 150) % 4;
      if ($urandom_range(0, 299) == 0) reset_pulse();
      step(($urandom % 4) != 0, ($urandom % 3) != 0, WIDTH'($urandom),
           ($urandom % 4) < bias);
    end
    idle_drain(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tx_fifo.md
TX_FIFO -- requirements
Module: tx_fifo

Interface
REQ-001 The block SHALL be clocked by PCLK and reset by CLEAR_B, with one clock and an asynchronous active-low reset.
REQ-002 Parameter DEPTH, default 4, is the number of entries and SHALL be a power of two that is at least 2.
REQ-003 Parameter WIDTH, default 8, is the data width in bits.
REQ-004 PCLK  input  1  rising-edge clock.
REQ-005 CLEAR_B  input  1  asynchronous active-low reset.
REQ-006 PSEL  input  1  bus select.
REQ-007 PWRITE  input  1  bus write strobe.
REQ-008 PWDATA  input  WIDTH  write data from the bus.
REQ-009 TxRDY  input  1  transmit logic can accept a word this cycle.
REQ-010 TxDATA  output  WIDTH  head-of-FIFO word presented to the transmit logic.
REQ-011 TxVALID  output  1  FIFO not empty, so TxDATA is meaningful.
REQ-012 TxFULL  output  1  all DEPTH entries are occupied.
REQ-013 SSPTXINTR  output  1  FIFO is half empty or emptier.
REQ-014 COUNT  output  log2(DEPTH)+1  current occupancy.
REQ-015 OVRERR  output  1  sticky flag for a write attempted while full.

Function
REQ-016 Storage SHALL be DEPTH registers with write pointer wp and read pointer rp, each log2(DEPTH) bits and wrapping modulo DEPTH; there is no separate flag per cell.
REQ-017 The write enable SHALL be wre = PSEL && PWRITE && !TxFULL; on a rising edge with wre, mem[wp] takes PWDATA and wp advances by 1.
REQ-018 The read enable SHALL be rde = TxVALID && TxRDY; on a rising edge with rde, rp advances by 1.
REQ-019 TxDATA SHALL equal mem[rp] combinationally (first-word fall-through), giving zero-cycle read latency; a word written on edge N is visible on TxDATA and TxVALID after edge N.
REQ-020 COUNT SHALL behave as follows: +1 on wre only, -1 on rde only, unchanged when both or neither are asserted.
REQ-021 The status outputs SHALL be TxVALID = (COUNT != 0), TxFULL = (COUNT == DEPTH), and SSPTXINTR = (COUNT <= DEPTH/2); all are decoded from registered COUNT and pointers.
REQ-022 When the FIFO is full, a write SHALL be rejected even if rde is asserted in the same cycle; the read still completes and COUNT becomes DEPTH-1.
REQ-023 When the FIFO is empty, rde is 0 by construction; a write in that cycle is accepted and COUNT becomes 1.
REQ-024 When neither full nor empty, simultaneous wre and rde SHALL both complete, both pointers advance, and COUNT is unchanged.
REQ-025 OVRERR SHALL be set on the edge where PSEL && PWRITE && TxFULL holds, and SHALL remain set until reset; mem, wp and COUNT are untouched by that write.
REQ-026 A bus read (PSEL && !PWRITE) SHALL have no effect on the FIFO.
REQ-027 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no lost or duplicated words over an arbitrary number of laps.

Reset
REQ-028 CLEAR_B low SHALL immediately, without waiting for PCLK, force wp=0, rp=0, COUNT=0 and OVRERR=0.
REQ-029 During reset the outputs SHALL be TxVALID=0, TxFULL=0 and SSPTXINTR=1; TxDATA is don't-care, and mem contents are not cleared.
REQ-030 Reset asserted mid-transfer SHALL discard all queued words, and the first write after release SHALL land in entry 0.
REQ-031 After CLEAR_B deasserts, the block SHALL accept a write on the first following PCLK edge.

Verification
REQ-032 With DEPTH=4 and TxRDY=0, write 0x11, 0x22, 0x33, 0x44 -> COUNT steps 1, 2, 3, 4; TxFULL=1 after the 4th write; SSPTXINTR=1 through COUNT=2 and 0 at COUNT 3 and 4; TxDATA=0x11.
REQ-033 While full, write 0x55 -> the write is rejected, OVRERR=1, COUNT=4; then raise TxRDY for 4 cycles -> TxDATA sequence 0x11, 0x22, 0x33, 0x44, then TxVALID=0 and OVRERR still 1.
REQ-034 While full, assert a write of 0x66 and TxRDY in the same cycle -> 0x11 is consumed, 0x66 is dropped, COUNT=3, TxFULL=0.
REQ-035 With COUNT=2, hold a write and TxRDY for 10 cycles with incrementing data -> COUNT stays 2 and the output order matches the input order across 3 pointer wraps.
REQ-036 From empty, write 0xA5 -> TxVALID=1 and TxDATA=0xA5 after the same edge; with TxRDY=1 on the next cycle, the FIFO empties.
REQ-037 Pulse CLEAR_B low between PCLK edges with COUNT=3 -> COUNT=0, TxVALID=0 and OVRERR=0 immediately; the next write of 0x77 appears at TxDATA.
